// File: rtl/reg_file_mp.sv
// Multi-port register file: two combinational read ports, two write ports, per-register pending
// scoreboard. Define REG_FILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module reg_file_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] rs_o,
    output logic [DATA_W-1:0] rt_o,
    output logic              rs_busy,
    output logic              rt_busy,
    input  logic              w0_en,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    input  logic              w1_en,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [Depth];
    logic [DATA_W-1:0] mem_d [Depth];
    logic [Depth-1:0]  pend_q, pend_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    always_comb begin
        mem_d = mem_q;
        if (w0_en && !is_zero(w0_addr)) mem_d[w0_addr] = w0_data;
        // w1 is applied last so it wins a same-address collision
        if (w1_en && !is_zero(w1_addr)) mem_d[w1_addr] = w1_data;
    end

    always_comb begin
        pend_d = pend_q;
        if (w0_en) pend_d[w0_addr] = 1'b0;
        if (w1_en) pend_d[w1_addr] = 1'b0;
        // Issue after writes: a newer producer keeps the register pending
        if (iss_en) pend_d[iss_addr] = 1'b1;
        if (ZERO_REG) pend_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < Depth; i++) begin
            cnt_d = cnt_d + (ADDR_W + 1)'(pend_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '{default: '0};
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] d;
        d = mem_q[a];
`ifdef REG_FILE_BYPASS_EN
        if (rst_n) begin
            if (w0_en && w0_addr == a) d = w0_data;
            if (w1_en && w1_addr == a) d = w1_data;
        end
`endif
        if (is_zero(a)) d = '0;
        return d;
    endfunction

    function automatic logic read_busy(input logic [ADDR_W-1:0] a);
        logic b;
        b = pend_q[a];
`ifdef REG_FILE_BYPASS_EN
        if (rst_n && ((w0_en && w0_addr == a) || (w1_en && w1_addr == a))) b = 1'b0;
`endif
        if (is_zero(a)) b = 1'b0;
        return b;
    endfunction

    always_comb begin
        rs_o     = read_data(rs);
        rt_o     = read_data(rt);
        rs_busy  = read_busy(rs);
        rt_busy  = read_busy(rt);
        pend_cnt = cnt_q;
    end

endmodule
